bsg_gen: RTL
============

BSG_GEN -- requirements
Module: bsg_gen

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
REQ-003 SHALL have port start  input  1  request to begin one stream; sampled only in IDLE or DONE.
REQ-004 SHALL have port abort  input  1  synchronous stop of a running stream.
REQ-005 SHALL have port value_a  input  8  unsigned lane-0 density, count of ones per stream.
REQ-006 SHALL have port value_b  input  8  unsigned lane-1 density, count of ones per stream.
REQ-007 SHALL have port x  output  2  registered bitstream pair; x[0] is lane 0, x[1] is lane 1; drives the bitstream-averager x input.
REQ-008 SHALL have port x_valid  output  1  high while x carries stream bits.
REQ-009 SHALL have port busy  output  1  high in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last stream bit.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE; DONE lasts exactly one cycle, then goes to IDLE unless restarted.
REQ-012 SHALL, in IDLE or DONE with start=1, latch value_a/value_b, load the LFSR with the seed, clear the bit counter and enter RUN on that edge.
REQ-013 SHALL ignore start and any changes on value_a/value_b while in RUN.
REQ-014 SHALL step one 8-bit Fibonacci LFSR per RUN cycle: shift left, new bit0 = q[7]^q[5]^q[4]^q[3], period 255, never 0.
REQ-015 SHALL produce registered x[0] = (lfsr <= value_a_latched) and x[1] = (bitrev(lfsr) <= value_b_latched).
REQ-016 SHALL hold x_valid=1 for exactly 255 consecutive cycles, starting the cycle after the start edge, so each lane emits exactly value ones per stream (0 gives all zeros, 255 gives all ones).
REQ-017 SHALL count emitted bits with an 8-bit counter; after bit 255, SHALL enter DONE with done=1, x_valid=0, x=0.
REQ-018 SHALL allow start during the DONE cycle, giving back-to-back streams with exactly one x_valid=0 gap cycle.
REQ-019 SHALL, on abort=1 in RUN, go to IDLE on that edge with x_valid=0, x=0, busy=0 and no done pulse; abort SHALL take priority over stream completion in the same cycle.
REQ-020 SHALL ignore abort outside RUN; if start and abort are both high in IDLE, start SHALL win.
REQ-021 SHALL drive x=0 whenever x_valid=0.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, x=0, x_valid=0, busy=0, done=0, counter=0, latched values=0 and LFSR=8'h01, independent of clk.
REQ-023 SHALL, after reset is asserted mid-stream, produce no done pulse and no resumption of the aborted stream after reset is released.
REQ-024 SHALL leave the first edge after rst_n deasserts in IDLE and SHALL sample start normally on that edge.

Configuration
REQ-025 SHALL, with BSG_SEED_LOAD_EN defined, add input seed[7:0], latched at start as the LFSR start value, with 8'h00 replaced by 8'h01.
REQ-026 SHALL, without BSG_SEED_LOAD_EN, have no seed port and always use seed 8'h01; ones-count per stream SHALL be identical in both builds.

Verification
REQ-027 SHALL cover: value_a=0, value_b=255, start pulse -> 255 valid cycles, lane 0 all zeros, lane 1 all ones, done=1 on cycle 256.
REQ-028 SHALL cover: value_a=128, value_b=64 -> exactly 128 and 64 ones respectively, with the first x_valid cycle one clock after the start edge.
REQ-029 SHALL cover: start re-pulsed at RUN cycle 50 with new values -> stream unchanged, single done pulse.
REQ-030 SHALL cover: abort at RUN cycle 10 -> next cycle x_valid=0, busy=0, x=0, and no done pulse.
REQ-031 SHALL cover: rst_n low at RUN cycle 100 -> all outputs 0 immediately, and a later start with value_a=7 yields exactly 7 ones.
REQ-032 SHALL cover: start held during DONE -> second stream starts with exactly one gap cycle; with BSG_SEED_LOAD_EN, seed=8'h00 behaves like seed 8'h01.

Source files
------------

// File: rtl/bsg_gen_if.sv
// Handshake and bitstream bundle for bsg_gen; the seed input exists only when
// BSG_SEED_LOAD_EN is defined.
interface bsg_gen_if;
  logic       start;
  logic       abort;
  logic [7:0] value_a;
  logic [7:0] value_b;
`ifdef BSG_SEED_LOAD_EN
  logic [7:0] seed;
`endif
  logic [1:0] x;
  logic       x_valid;
  logic       busy;
  logic       done;

  modport master (
`ifdef BSG_SEED_LOAD_EN
    output seed,
`endif
    output start, abort, value_a, value_b,
    input  x, x_valid, busy, done
  );

  modport slave (
`ifdef BSG_SEED_LOAD_EN
    input  seed,
`endif
    input  start, abort, value_a, value_b,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/bsg_gen.sv
// Two-lane stochastic bitstream generator: one 255-bit stream per start, lane
// density set by value_a/value_b. Optional seed input under BSG_SEED_LOAD_EN.
module bsg_gen (
  input  logic       clk,
  input  logic       rst_n,
  bsg_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // The counter holds the index of the bit currently on x; 254 is the 255th.
  localparam logic [7:0] LAST_IDX = 8'd254;

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] val_a_q, val_a_d;
  logic [7:0] val_b_q, val_b_d;
  logic [1:0] x_q, x_d;
  logic [7:0] seed_w;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

`ifdef BSG_SEED_LOAD_EN
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  assign seed_w = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
`else
  assign seed_w = 8'h01;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    val_a_d = val_a_q;
    val_b_d = val_b_q;
    x_d     = 2'b00;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          val_a_d = bus.value_a;
          val_b_d = bus.value_b;
          lfsr_d  = seed_w;
          cnt_d   = 8'd0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
          cnt_d  = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // x is computed from next state so the registered bit lines up with x_valid.
    if (state_d == RUN) begin
      x_d = {bitrev(lfsr_d) <= val_b_d, lfsr_d <= val_a_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 8'h01;
      cnt_q   <= 8'd0;
      val_a_q <= 8'd0;
      val_b_q <= 8'd0;
      x_q     <= 2'b00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      val_a_q <= val_a_d;
      val_b_q <= val_b_d;
      x_q     <= x_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = (state_q == RUN);
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule
